// File: rtl/data_cache_flush_ctrl.sv
// Flush/refill sequencer for one data-cache block: walks every qword, writes dirty ones back
// to memory and (in refill mode) reloads clean ones. Optional macro: DCACHE_FLUSH_WB_COUNT_EN.
module data_cache_flush_ctrl #(
  parameter int ADDR_WIDTH = 5,
  parameter int MEM_AW     = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      start_i,
  input  logic                      refill_i,
  input  logic [MEM_AW-1:0]         base_addr_i,
  output logic                      busy_o,
  output logic                      done_o,
  input  logic [2**(ADDR_WIDTH-2)-1:0] dirty_i,
  output logic [ADDR_WIDTH-3:0]     addr_r_o,
  input  logic [31:0]               data0_i,
  input  logic [31:0]               data1_i,
  input  logic [31:0]               data2_i,
  input  logic [31:0]               data3_i,
  output logic [127:0]              flush_data_o,
  output logic [2**(ADDR_WIDTH-2)-1:0] flushing_n_o,
  output logic                      cleaned_n_o,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [MEM_AW-1:0]         mem_addr_o,
  output logic [127:0]              mem_wdata_o,
  input  logic [127:0]              mem_rdata_i,
  input  logic                      mem_ack_i,
  output logic [ADDR_WIDTH-2:0]     wb_count_o
);

  localparam int QWC = 2**(ADDR_WIDTH-2);
  localparam int KW  = ADDR_WIDTH-2;
  localparam int HW  = MEM_AW-4-KW;

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_RD, S_WB_REQ, S_RF_REQ, S_COMMIT_WB, S_COMMIT_RF, S_NEXT, S_DONE
  } state_t;

  state_t          state_reg, state_next;
  logic [KW-1:0]   k_reg;
  logic            refill_reg;
  logic [HW-1:0]   base_reg;
  logic [127:0]    wdata_reg;
  logic [127:0]    fdata_reg;
  logic            commit;
  logic            last_qword;
  logic            unused_base_bits;

  // Only the block-aligned part of the base address matters.
  assign unused_base_bits = ^base_addr_i[KW+3:0];
  assign last_qword       = (k_reg == KW'(QWC-1));

  always_ff @(posedge clk_i) begin
    if (rst_i) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:      if (start_i) state_next = S_CHECK;
      S_CHECK: begin
        if (dirty_i[k_reg])  state_next = S_RD;
        else if (refill_reg) state_next = S_RF_REQ;
        else                 state_next = S_NEXT;
      end
      S_RD:        state_next = S_WB_REQ;
      S_WB_REQ:    if (mem_ack_i) state_next = S_COMMIT_WB;
      S_RF_REQ:    if (mem_ack_i) state_next = S_COMMIT_RF;
      S_COMMIT_WB: state_next = S_NEXT;
      S_COMMIT_RF: state_next = S_NEXT;
      S_NEXT:      state_next = last_qword ? S_DONE : S_CHECK;
      S_DONE:      state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o      = 1'b0;
    done_o      = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    commit      = 1'b0;
    cleaned_n_o = 1'b1;
    case (state_reg)
      S_IDLE:      busy_o = 1'b0;
      S_DONE:      done_o = 1'b1;
      S_WB_REQ: begin
        busy_o    = 1'b1;
        mem_req_o = 1'b1;
        mem_we_o  = 1'b1;
      end
      S_RF_REQ: begin
        busy_o    = 1'b1;
        mem_req_o = 1'b1;
      end
      S_COMMIT_WB, S_COMMIT_RF: begin
        busy_o      = 1'b1;
        commit      = 1'b1;
        cleaned_n_o = 1'b0;
      end
      default:     busy_o = 1'b1;
    endcase
  end

  // Datapath registers; request outputs come from registers so they hold stable until ack.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      k_reg      <= '0;
      refill_reg <= 1'b0;
      base_reg   <= '0;
      wdata_reg  <= '0;
      fdata_reg  <= '0;
    end else begin
      case (state_reg)
        S_IDLE: if (start_i) begin
          refill_reg <= refill_i;
          base_reg   <= base_addr_i[MEM_AW-1:KW+4];
          k_reg      <= '0;
        end
        S_RD:     wdata_reg <= {data3_i, data2_i, data1_i, data0_i};
        S_RF_REQ: if (mem_ack_i) fdata_reg <= mem_rdata_i;
        S_NEXT:   if (!last_qword) k_reg <= k_reg + KW'(1);
        default: ;
      endcase
    end
  end

  assign addr_r_o     = k_reg;
  assign mem_addr_o   = {base_reg, k_reg, 4'b0000};
  assign mem_wdata_o  = wdata_reg;
  assign flush_data_o = fdata_reg;

  genvar gi;
  generate
    for (gi = 0; gi < QWC; gi++) begin : g_strobe
      assign flushing_n_o[gi] = ~(commit && (k_reg == KW'(gi)));
    end
  endgenerate

`ifdef DCACHE_FLUSH_WB_COUNT_EN
  logic [KW:0] wb_count_reg;

  always_ff @(posedge clk_i) begin
    if (rst_i)                               wb_count_reg <= '0;
    else if (state_reg == S_IDLE && start_i) wb_count_reg <= '0;
    else if (state_reg == S_COMMIT_WB)       wb_count_reg <= wb_count_reg + (KW+1)'(1);
  end

  assign wb_count_o = wb_count_reg;
`else
  assign wb_count_o = '0;
`endif

endmodule

// File: tb/tb_data_cache_flush_ctrl.sv
// Scoreboard bench for data_cache_flush_ctrl: a qword-level model predicts memory transactions,
// commit strobes and done pulses; a monitor compares them as the DUT presents them.
module tb_data_cache_flush_ctrl;
  localparam int AW  = 5;
  localparam int QWC = 8;
  localparam int MAW = 32;

  logic clk, rst_i, start_i, refill_i;
  logic [MAW-1:0] base_addr_i;
  logic busy_o, done_o;
  logic [QWC-1:0] dirty_i;
  logic [AW-3:0] addr_r_o;
  logic [31:0] data0_i, data1_i, data2_i, data3_i;
  logic [127:0] flush_data_o;
  logic [QWC-1:0] flushing_n_o;
  logic cleaned_n_o, mem_req_o, mem_we_o;
  logic [MAW-1:0] mem_addr_o;
  logic [127:0] mem_wdata_o, mem_rdata_i;
  logic mem_ack_i;
  logic [AW-2:0] wb_count_o;

  data_cache_flush_ctrl #(.ADDR_WIDTH(AW), .MEM_AW(MAW)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .refill_i(refill_i),
    .base_addr_i(base_addr_i), .busy_o(busy_o), .done_o(done_o), .dirty_i(dirty_i),
    .addr_r_o(addr_r_o), .data0_i(data0_i), .data1_i(data1_i), .data2_i(data2_i),
    .data3_i(data3_i), .flush_data_o(flush_data_o), .flushing_n_o(flushing_n_o),
    .cleaned_n_o(cleaned_n_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .mem_ack_i(mem_ack_i), .wb_count_o(wb_count_o)
  );

  typedef struct {
    int           kind;      // 0 memory transaction, 1 commit, 2 done
    logic         we;
    logic [31:0]  addr;
    logic [127:0] data;
    int           k;
    logic         chk_data;
    int           wbc;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int fails = 0;
  logic [127:0] cache [QWC];
  int delay_mode = 0;
  int cur_delay = 0;
  int wait_cnt = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic logic [127:0] mem_val(input logic [31:0] a);
    return {a ^ 32'h1234_5678, ~a, a + 32'h0000_1111, {a[15:0], a[31:16]}};
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Expected behaviour of one operation, qword by qword.
  task automatic push_op(input logic [7:0] dirty, input logic rf, input logic [31:0] base);
    logic [31:0] a;
    int cnt = 0;
    exp_t e;
    for (int k = 0; k < QWC; k++) begin
      a = (base & ~32'h7F) + 32'(16 * k);
      if (dirty[k]) begin
        e = '{0, 1'b1, a, cache[k], k, 1'b0, 0}; exp_q.push_back(e);
        e = '{1, 1'b0, a, 128'h0, k, 1'b0, 0};   exp_q.push_back(e);
        cnt++;
      end else if (rf) begin
        e = '{0, 1'b0, a, 128'h0, k, 1'b0, 0};     exp_q.push_back(e);
        e = '{1, 1'b0, a, mem_val(a), k, 1'b1, 0}; exp_q.push_back(e);
      end
    end
`ifdef DCACHE_FLUSH_WB_COUNT_EN
    e = '{2, 1'b0, 32'h0, 128'h0, 0, 1'b0, cnt};
`else
    e = '{2, 1'b0, 32'h0, 128'h0, 0, 1'b0, 0};
`endif
    exp_q.push_back(e);
  endtask

  // Cache read port: one-cycle latency from addr_r_o.
  initial begin
    logic [AW-3:0] ra;
    {data3_i, data2_i, data1_i, data0_i} = '0;
    forever begin
      @(negedge clk); #1 ra = addr_r_o;
      @(posedge clk); #1 {data3_i, data2_i, data1_i, data0_i} = cache[ra];
    end
  end

  // Memory responder: ack after cur_delay waiting cycles.
  initial begin
    mem_ack_i = 0;
    mem_rdata_i = '0;
    forever begin
      @(negedge clk); #1;
      if (mem_req_o && !rst_i) begin
        if (wait_cnt >= cur_delay) begin
          mem_ack_i = 1;
          mem_rdata_i = mem_val(mem_addr_o);
        end else begin
          mem_ack_i = 0;
          mem_rdata_i = {$urandom, $urandom, $urandom, $urandom};
          wait_cnt++;
        end
      end else begin
        mem_ack_i = 0;
        wait_cnt = 0;
        cur_delay = (delay_mode < 0) ? int'($urandom_range(0, 3)) : delay_mode;
      end
    end
  end

  task automatic pop_exp(input int kind, output exp_t e, output bit ok);
    ok = 0;
    checks++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL unexpected_event: got kind %0d expected none", kind);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind) begin
        fails++;
        $display("FAIL event_kind: got %0d expected %0d (k=%0d)", kind, e.kind, e.k);
      end else ok = 1;
    end
  endtask

  // Monitor samples just before the next active edge.
  initial begin
    bit req_prev = 0;
    int req_cycles = 0;
    logic snap_we;
    logic [31:0] snap_addr;
    logic [127:0] snap_wdata;
    logic [7:0] m;
    exp_t e;
    bit ok;
    forever begin
      @(negedge clk); #2;
      if (rst_i) begin
        req_prev = 0;
      end else begin
        if (mem_req_o) begin
          if (!req_prev) begin
            snap_we = mem_we_o; snap_addr = mem_addr_o; snap_wdata = mem_wdata_o;
            req_cycles = 1;
          end else begin
            req_cycles++;
            check("req_stable_addr", {mem_we_o, mem_addr_o}, {snap_we, snap_addr});
            check("req_stable_wdata", mem_wdata_o, snap_wdata);
          end
          if (mem_ack_i) begin
            pop_exp(0, e, ok);
            if (ok) begin
              check("mem_we", mem_we_o, e.we);
              check("mem_addr", mem_addr_o, e.addr);
              if (e.we) check("mem_wdata", mem_wdata_o, e.data);
              check("req_cycles", req_cycles, cur_delay + 1);
            end
          end
        end
        req_prev = mem_req_o && !mem_ack_i;
        if (flushing_n_o != 8'hFF) begin
          pop_exp(1, e, ok);
          if (ok) begin
            m = 8'hFF; m[e.k] = 1'b0;
            check("flushing_n", flushing_n_o, m);
            check("cleaned_n_commit", cleaned_n_o, 1'b0);
            if (e.chk_data) check("flush_data", flush_data_o, e.data);
          end
        end else begin
          check("cleaned_n_idle", cleaned_n_o, 1'b1);
        end
        if (done_o) begin
          pop_exp(2, e, ok);
          if (ok) begin
            check("wb_count", wb_count_o, e.wbc);
            check("busy_at_done", busy_o, 1'b0);
          end
        end
      end
    end
  end

  task automatic run_start(input logic [7:0] dirty, input logic rf, input logic [31:0] base,
                           input bit hold);
    @(negedge clk);
    dirty_i = dirty; refill_i = rf; base_addr_i = base; start_i = 1;
    push_op(dirty, rf, base);
    $display("start dirty=%02h refill=%0d base=%08h", dirty, rf, base);
    @(negedge clk);
    if (!hold) start_i = 0;
    #3;
    check("busy_after_start", busy_o, 1'b1);
    check("wb_count_cleared", wb_count_o, 0);
  endtask

  task automatic wait_done();
    int n = 0;
    bit timed_out = 0;
    forever begin
      @(negedge clk); #3;
      if (done_o) break;
      n++;
      if (n > 600) begin timed_out = 1; break; end
    end
    checks++;
    if (timed_out) begin
      fails++;
      $display("FAIL done_timeout: got no done expected done within 600 cycles");
    end
  endtask

  task automatic fill_cache();
    for (int i = 0; i < QWC; i++) cache[i] = {$urandom, $urandom, $urandom, $urandom};
  endtask

  initial begin
    logic [31:0] w0;
    int n;
    rst_i = 1; start_i = 0; refill_i = 0; base_addr_i = '0; dirty_i = '0;
    fill_cache();
    repeat (3) @(negedge clk);
    #3;
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_flushing_n", flushing_n_o, 8'hFF);
    check("rst_cleaned_n", cleaned_n_o, 1'b1);
    check("rst_req_we", {mem_req_o, mem_we_o}, 2'b00);
    check("rst_addr_r", addr_r_o, 0);
    check("rst_flush_data", flush_data_o, 0);
    check("rst_wdata", mem_wdata_o, 0);
    check("rst_wb_count", wb_count_o, 0);
    rst_i = 0;

    // All clean, refill, zero-latency memory.
    delay_mode = 0;
    run_start(8'h00, 1, 32'h1000, 0);
    wait_done();

    // Write-back only of qwords 0 and 2.
    w0 = 32'hDDCCBBAA;
    cache[0] = {32'h44332211, 32'h88776655, 32'hCCBBAA99, w0};
    run_start(8'h05, 0, 32'h1000, 0);
    wait_done();

    // Slow memory, last qword dirty.
    delay_mode = 3;
    run_start(8'h80, 1, 32'h1000, 0);
    wait_done();

    // start held high: one done, restart only after IDLE.
    delay_mode = 0;
    run_start(8'h3C, 1, 32'h2000, 1);
    push_op(8'h3C, 1, 32'h2000);
    wait_done();
    @(negedge clk); #3;
    check("idle_between_ops", busy_o, 1'b0);
    @(negedge clk); #3;
    check("restart_busy", busy_o, 1'b1);
    start_i = 0;
    wait_done();
    @(negedge clk); #3;
    check("no_extra_op", busy_o, 1'b0);

    // Reset while writing back qword 3.
    delay_mode = 6;
    run_start(8'h08, 0, 32'h1000, 0);
    n = 0;
    while (!(mem_req_o && mem_addr_o == 32'h1030) && n < 100) begin
      @(negedge clk); #3; n++;
    end
    check("reach_wb_q3", mem_addr_o, 32'h1030);
    rst_i = 1;
    exp_q.delete();
    @(negedge clk); #3;
    check("mid_rst_req", mem_req_o, 1'b0);
    check("mid_rst_flushing_n", flushing_n_o, 8'hFF);
    check("mid_rst_busy", busy_o, 1'b0);
    rst_i = 0;

    // Back-to-back operations with different bases (low base bits ignored).
    delay_mode = -1;
    fill_cache();
    run_start(8'hA5, 1, 32'h0000_4000, 0);
    wait_done();
    run_start(8'h5A, 0, 32'h8000_3F7C, 0);
    wait_done();

    for (int t = 0; t < 6; t++) begin
      fill_cache();
      run_start(8'($urandom), 1'($urandom), $urandom, 0);
      wait_done();
    end

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
